// File: rtl/hazard_unit.sv
// Hazard unit: load-use stall, taken-branch flush and data-memory wait/timeout
// control for the pipeline registers, plus saturating stall/flush counters.
module hazard_unit #(
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       de_rs1,
   input  logic [4:0]       de_rs2,
   input  logic             de_rs1_used,
   input  logic             de_rs2_used,
   input  logic [4:0]       ex_rd,
   input  logic             ex_ruwr,
   input  logic             ex_dmrd,
   input  logic             ex_br_taken,
   input  logic             me_dm_req,
   input  logic             me_dm_ready,
   output logic             pc_we,
   output logic             if_de_we,
   output logic             de_ex_we,
   output logic             ex_me_we,
   output logic             if_de_flush,
   output logic             de_ex_flush,
   output logic             me_wb_flush,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [1:0] {RUN, MEM_WAIT, TIMEOUT} state_t;

   // wait_cnt only needs to reach MEM_TIMEOUT-1; with the timeout disabled it may wrap freely
   localparam int WC_W  = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam int TO_M1 = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;

   state_t            state_q, state_d;
   logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic              timeout_q, timeout_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
   logic              mem_wait, load_use, br_flush;

   assign mem_wait = me_dm_req & ~me_dm_ready;
   assign load_use = ex_dmrd & ex_ruwr & (ex_rd != 5'd0) &
                     ((de_rs1_used & (de_rs1 == ex_rd)) | (de_rs2_used & (de_rs2 == ex_rd)));

   // Next state and pipeline control; memory wait beats branch beats load-use
   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      pc_we       = 1'b1;
      if_de_we    = 1'b1;
      de_ex_we    = 1'b1;
      ex_me_we    = 1'b1;
      if_de_flush = 1'b0;
      de_ex_flush = 1'b0;
      me_wb_flush = 1'b0;
      br_flush    = 1'b0;
      case (state_q)
         RUN, MEM_WAIT: begin
            if (mem_wait) begin
               pc_we       = 1'b0;
               if_de_we    = 1'b0;
               de_ex_we    = 1'b0;
               ex_me_we    = 1'b0;
               me_wb_flush = 1'b1;
               wait_cnt_d  = wait_cnt_q + 1'b1;
               state_d     = MEM_WAIT;
               if ((MEM_TIMEOUT != 0) && (wait_cnt_q == WC_W'(TO_M1)))
                  state_d = TIMEOUT;
            end else begin
               // The ready cycle is the first non-waiting cycle: a branch held in EX during
               // the wait is flushed here, otherwise it would slip into MEM unflushed.
               state_d    = RUN;
               wait_cnt_d = '0;
               if (ex_br_taken) begin
                  if_de_flush = 1'b1;
                  de_ex_flush = 1'b1;
                  br_flush    = 1'b1;
               end else if (load_use) begin
                  pc_we       = 1'b0;
                  if_de_we    = 1'b0;
                  de_ex_flush = 1'b1;
               end
            end
         end
         TIMEOUT: begin
            pc_we       = 1'b0;
            if_de_we    = 1'b0;
            de_ex_we    = 1'b0;
            ex_me_we    = 1'b0;
            me_wb_flush = 1'b1;
         end
         default: state_d = RUN;
      endcase
      if (rst) begin
         pc_we       = 1'b1;
         if_de_we    = 1'b1;
         de_ex_we    = 1'b1;
         ex_me_we    = 1'b1;
         if_de_flush = 1'b0;
         de_ex_flush = 1'b0;
         me_wb_flush = 1'b0;
         br_flush    = 1'b0;
      end
   end

   // Sticky timeout flag and saturating event counters
   always_comb begin
      timeout_d   = timeout_q | (state_d == TIMEOUT);
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (!pc_we && (stall_cnt_q != '1))
         stall_cnt_d = stall_cnt_q + 1'b1;
      if (br_flush && (flush_cnt_q != '1))
         flush_cnt_d = flush_cnt_q + 1'b1;
   end

   // State and counter registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= RUN;
         wait_cnt_q  <= '0;
         timeout_q   <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         timeout_q   <= timeout_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign mem_timeout = timeout_q;
   assign stall_cnt   = stall_cnt_q;
   assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: table of single-cycle vectors in RUN plus hand sequences
// for memory wait, timeout and reset-in-wait; control outputs are checked through
// a scoreboard queue, counters against a running model.
module tb_hazard_unit;

   localparam int CW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic [4:0]    de_rs1, de_rs2, ex_rd;
   logic          de_rs1_used, de_rs2_used, ex_ruwr, ex_dmrd, ex_br_taken;
   logic          me_dm_req, me_dm_ready;
   logic          pc_we, if_de_we, de_ex_we, ex_me_we;
   logic          if_de_flush, de_ex_flush, me_wb_flush, mem_timeout;
   logic [CW-1:0] stall_cnt, flush_cnt;

   hazard_unit #(.MEM_TIMEOUT(4), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .de_rs1(de_rs1), .de_rs2(de_rs2), .de_rs1_used(de_rs1_used), .de_rs2_used(de_rs2_used),
      .ex_rd(ex_rd), .ex_ruwr(ex_ruwr), .ex_dmrd(ex_dmrd), .ex_br_taken(ex_br_taken),
      .me_dm_req(me_dm_req), .me_dm_ready(me_dm_ready),
      .pc_we(pc_we), .if_de_we(if_de_we), .de_ex_we(de_ex_we), .ex_me_we(ex_me_we),
      .if_de_flush(if_de_flush), .de_ex_flush(de_ex_flush), .me_wb_flush(me_wb_flush),
      .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   // ctrl = {pc_we, if_de_we, de_ex_we, ex_me_we, if_de_flush, de_ex_flush, me_wb_flush, mem_timeout}
   localparam logic [7:0] DEF = 8'b1111_0000;
   localparam logic [7:0] LU  = 8'b0011_0100;
   localparam logic [7:0] BR  = 8'b1111_1100;
   localparam logic [7:0] WT  = 8'b0000_0010;
   localparam logic [7:0] TO  = 8'b0000_0011;

   typedef struct {
      logic [4:0] rs1, rs2, rd;
      logic       u1, u2, ruwr, dmrd, br, req, rdy;
      logic [7:0] exp;
      string      name;
   } vec_t;

   int          errors = 0;
   int          checks = 0;
   int          stall_m = 0;
   int          flush_m = 0;
   logic [7:0]  sb_q[$];

   function automatic vec_t mk(input string n, input logic [4:0] rs1, input logic u1,
                               input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                               input logic ruwr, input logic dmrd, input logic br,
                               input logic req, input logic rdy, input logic [7:0] exp);
      vec_t v;
      v.name = n; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2; v.rd = rd;
      v.ruwr = ruwr; v.dmrd = dmrd; v.br = br; v.req = req; v.rdy = rdy; v.exp = exp;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      de_rs1 = v.rs1; de_rs2 = v.rs2; de_rs1_used = v.u1; de_rs2_used = v.u2;
      ex_rd = v.rd; ex_ruwr = v.ruwr; ex_dmrd = v.dmrd; ex_br_taken = v.br;
      me_dm_req = v.req; me_dm_ready = v.rdy;
   endtask

   // One cycle: drive, push expectation, compare at negedge, advance model after the edge
   task automatic step(input vec_t v);
      logic [7:0] act, exp;
      drive(v);
      sb_q.push_back(v.exp);
      @(negedge clk);
      exp = sb_q.pop_front();
      act = {pc_we, if_de_we, de_ex_we, ex_me_we, if_de_flush, de_ex_flush, me_wb_flush, mem_timeout};
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s ctrl: got %b want %b", v.name, act, exp);
      end
      checks++;
      if (stall_cnt !== CW'(stall_m)) begin
         errors++;
         $display("FAIL %s stall_cnt: got %0d want %0d", v.name, stall_cnt, stall_m);
      end
      checks++;
      if (flush_cnt !== CW'(flush_m)) begin
         errors++;
         $display("FAIL %s flush_cnt: got %0d want %0d", v.name, flush_cnt, flush_m);
      end
      if (!exp[7]) stall_m++;
      if (exp[3])  flush_m++;
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      stall_m = 0;
      flush_m = 0;
   endtask

   vec_t tbl[$];
   vec_t idle, wt, rdy;

   initial begin
      idle = mk("idle", 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, DEF);
      drive(idle);
      rst = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;

      //             name           rs1  u1  rs2  u2  rd  ruwr dmrd br  req rdy exp
      tbl.push_back(mk("reset_idle",  5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0, DEF));
      tbl.push_back(mk("lu_rs1",      5'd5, 1, 5'd0, 0, 5'd5, 1, 1, 0, 0, 0, LU));
      tbl.push_back(mk("after_lu",    5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0, DEF));
      tbl.push_back(mk("load_x0",     5'd0, 1, 5'd0, 1, 5'd0, 1, 1, 0, 0, 0, DEF));
      tbl.push_back(mk("rs2_unused",  5'd1, 0, 5'd5, 0, 5'd5, 1, 1, 0, 0, 0, DEF));
      tbl.push_back(mk("lu_rs2",      5'd1, 1, 5'd9, 1, 5'd9, 1, 1, 0, 0, 0, LU));
      tbl.push_back(mk("alu_no_lu",   5'd5, 1, 5'd0, 0, 5'd5, 1, 0, 0, 0, 0, DEF));
      tbl.push_back(mk("ld_no_wr",    5'd5, 1, 5'd0, 0, 5'd5, 0, 1, 0, 0, 0, DEF));
      tbl.push_back(mk("rd_mismatch", 5'd6, 1, 5'd7, 1, 5'd5, 1, 1, 0, 0, 0, DEF));
      tbl.push_back(mk("br_over_lu",  5'd5, 1, 5'd0, 0, 5'd5, 1, 1, 1, 0, 0, BR));
      tbl.push_back(mk("br_alone",    5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 0, 0, BR));
      tbl.push_back(mk("req_ready",   5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 1, 1, DEF));
      tbl.push_back(mk("lu_rs1_x31",  5'd31,1, 5'd0, 0, 5'd31,1, 1, 0, 0, 0, LU));
      foreach (tbl[i]) step(tbl[i]);

      // Memory wait: 3 wait cycles then ready, twice (wait_cnt must clear on ready)
      wt  = mk("mem_wait", 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 1, 0, WT);
      rdy = mk("mem_ready", 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 1, 1, DEF);
      do_reset();
      for (int r = 0; r < 2; r++) begin
         for (int k = 0; k < 3; k++) step(wt);
         step(rdy);
         step(idle);
      end
      // back in RUN: a load-use is acted on again
      step(mk("lu_after_wait", 5'd5, 1, 5'd0, 0, 5'd5, 1, 1, 0, 0, 0, LU));
      // load-use and branch are suppressed by a memory wait
      step(mk("wait_over_br", 5'd5, 1, 5'd0, 0, 5'd5, 1, 1, 1, 1, 0, WT));
      step(rdy);

      // Timeout: 4 wait cycles, then sticky TIMEOUT regardless of inputs
      do_reset();
      for (int k = 0; k < 4; k++) step(wt);
      step(mk("timeout", 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 1, 1, TO));
      step(mk("timeout_hold", 5'd5, 1, 5'd0, 0, 5'd5, 1, 1, 1, 0, 0, TO));
      step(mk("timeout_idle", 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0, TO));
      do_reset();
      step(mk("post_to_rst", 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0, DEF));

      // Reset during cycle 2 of a memory wait
      step(wt);
      drive(wt);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({pc_we, if_de_we, de_ex_we, ex_me_we, if_de_flush, de_ex_flush, me_wb_flush} !== DEF[7:1]) begin
         errors++;
         $display("FAIL rst_in_wait ctrl: got %b want %b",
                  {pc_we, if_de_we, de_ex_we, ex_me_we, if_de_flush, de_ex_flush, me_wb_flush}, DEF[7:1]);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      stall_m = 0;
      flush_m = 0;
      step(mk("after_rst_wait", 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0, DEF));
      step(mk("lu_after_rst", 5'd3, 1, 5'd0, 0, 5'd3, 1, 1, 0, 0, 0, LU));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
